wave_sched: RTL
===============

# wave_sched

Programmable waveform sequencer that drives a single-bit stimulus signal `sig` at cycle-accurate scheduled times. Software or a bench loads a list of (delay, value) events into a small internal buffer, then pulses `start`. The block plays the list out against its own cycle counter and reports completion. It replaces hand-written `#delay` stimulus sequences with a synthesizable, clocked scheduler in the lab designs.

## Interface
- `DEPTH`, 8: event buffer entries, at least 2.
- `DLY_W`, 8: width of a per-event delay field.
- `TIME_W`, 16: width of the elapsed-cycle counter `now`.
- `CNT_W`, `$clog2(DEPTH+1)`: width of `count`. Derived; do not override.

Ports:
- `clk`  in  1  Clock. All logic is on the rising edge.
- `rst_n`  in  1  Reset, synchronous, active-low.
- `clear`  in  1  Empties the buffer. Honoured only in IDLE.
- `wr_valid`  in  1  Event write request.
- `wr_ready`  out  1  Buffer can accept a write.
- `wr_delay`  in  DLY_W  Cycles to wait before applying this event.
- `wr_value`  in  1  Value that `sig` takes when this event fires.
- `start`  in  1  Begin playback. Level-sampled.
- `busy`  out  1  Playback in progress.
- `done`  out  1  One-cycle pulse at the end of playback.
- `evt_pulse`  out  1  One-cycle pulse after each event is applied.
- `sig`  out  1  Scheduled waveform output.
- `now`  out  TIME_W  Cycles elapsed since `start` was accepted.
- `count`  out  CNT_W  Number of events stored.

## Operation
- States are IDLE and RUN.
- IDLE:
  - A write happens when `wr_valid && wr_ready`. It stores {`wr_delay`, `wr_value`} at index `count`, and `count` increments.
  - `wr_ready` = IDLE && `count` < DEPTH.
  - `clear` sets `count` to 0. `clear` has priority over a write in the same cycle.
- `start` sampled high in IDLE:
  - Go to RUN and set `busy`=1.
  - Load the play index to 0, load the down-counter with entry 0's delay, and set `now` to 0.
  - If `count`==0, stay in IDLE, pulse `done` in the next cycle, and leave `sig` unchanged.
  - `start` and `clear` in the same cycle: `start` wins; `clear` is ignored.
- RUN:
  - Each cycle, `now` increments and saturates at all-ones.
  - Each cycle the down-counter decrements. When it is 0 at an edge, the current entry fires:
    - `sig` takes `wr_value` of that entry.
    - `evt_pulse`=1 for the following cycle.
    - The index advances and the down-counter loads the next entry's delay.
  - When the last entry (index `count`-1) fires, return to IDLE at the same edge: `busy`=0 and `done`=1 for one cycle.
- The buffer is not consumed by playback. A second `start` replays the same list.
- In RUN, `start`, `wr_valid` and `clear` are ignored.
- `sig` holds its last value indefinitely after playback.

## Timing
- Reset values: state IDLE, `count`=0, `sig`=0, `busy`=0, `done`=0, `evt_pulse`=0, `now`=0, `wr_ready`=1. Buffer contents are don't-care.
- Let E0 be the edge that samples `start`. Event k fires at edge E0 + Σ_{j≤k}(delay_j + 1).
  - A delay of 0 therefore fires one edge after the previous event, or one edge after E0 for the first event.
- `sig`, `evt_pulse`, `busy`, `done` and `now` are all registered outputs; none is driven combinationally.
- `busy` goes high at E0 and low at the edge where the last event fires.
- `done` and the final `evt_pulse` are high in the same cycle.
- A new `start` is accepted in the cycle in which `done` is high.
- `now` reads 0 in the cycle after E0, then increments every cycle while `busy`=1. It holds its value in IDLE.
- Reset has priority over every other input, including in the middle of RUN. All outputs return to their reset values on the next edge, and `count` is cleared.
- The maximum run length is DEPTH·2^DLY_W cycles. `now` saturates and never wraps.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release.
  - Required: every output at its reset value; `wr_ready`=1.
- Single event:
  - Stimulus: write {delay=2, value=1}, then `start` at edge E0.
  - Required: `sig` rises at E0+3. `evt_pulse`, `done` and falling `busy` are all seen in that cycle. `now` reads 2 in the cycle before.
- Three-event replay:
  - Stimulus: load {1,1},{0,0},{3,1}, start, wait for `done`, then start again.
  - Required: `sig` edges at E0+2, E0+3 and E0+7 in both runs, with identical `now` values.
- Full, clear and ignored inputs:
  - Stimulus: write 8 events with DEPTH=8, then assert `wr_valid` again; next, assert `start` and `clear` in the same cycle; during RUN, assert `start`, `wr_valid` and `clear`.
  - Required: `wr_ready`=0 and `count`=8 after the 8th write, with the 9th write dropped. The same-cycle `start`/`clear` begins playback and `count` stays 8. The inputs during RUN are ignored.
- Empty start:
  - Stimulus: `count`=0, assert `start`.
  - Required: `done` pulses one cycle later, `busy` stays 0, and `sig` is unchanged.
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 midway through a 3-event run.
  - Required: `sig`=0, `busy`=0 and `count`=0 on the next edge, with no `done` pulse.

Source files
------------

// File: rtl/wave_sched.sv
// Cycle-accurate single-bit waveform sequencer: a small buffer of (delay, value)
// events is played out against a per-event down-counter after a start request.
module wave_sched #(
    parameter int DEPTH  = 8,
    parameter int DLY_W  = 8,
    parameter int TIME_W = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DLY_W-1:0]  wr_delay,
    input  logic              wr_value,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              evt_pulse,
    output logic              sig,
    output logic [TIME_W-1:0] now,
    output logic [CNT_W-1:0]  count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  dly_mem_q [DEPTH];
    logic              val_mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  nidx;
    logic [DLY_W-1:0]  dcnt_q, dcnt_d;
    logic [TIME_W-1:0] now_q, now_d;
    logic              sig_q, sig_d;
    logic              done_q, done_d;
    logic              evt_q, evt_d;
    logic              clear_eff;
    logic              wr_en;
    logic              last;

    assign wr_ready  = (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    // start outranks clear in the same cycle
    assign clear_eff = (state_q == IDLE) && clear && !start;
    assign wr_en     = wr_valid && wr_ready && !clear_eff;
    assign last      = (CNT_W'(idx_q) + CNT_W'(1)) == count_q;
    assign nidx      = last ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        now_d   = now_q;
        sig_d   = sig_q;
        done_d  = 1'b0;
        evt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_eff) begin
                    count_d = '0;
                end else if (wr_en) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (start) begin
                    if (count_q != '0) begin
                        state_d = RUN;
                        idx_d   = '0;
                        dcnt_d  = dly_mem_q[0];
                        now_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (now_q != '1) begin
                    now_d = now_q + TIME_W'(1);
                end
                if (dcnt_q == '0) begin
                    sig_d = val_mem_q[idx_q];
                    evt_d = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = nidx;
                        dcnt_d = dly_mem_q[nidx];
                    end
                end else begin
                    dcnt_d = dcnt_q - DLY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dcnt_q  <= '0;
            now_q   <= '0;
            sig_q   <= 1'b0;
            done_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            now_q   <= now_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
            evt_q   <= evt_d;
        end
    end

    // Buffer contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            dly_mem_q[count_q[IDX_W-1:0]] <= wr_delay;
            val_mem_q[count_q[IDX_W-1:0]] <= wr_value;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign evt_pulse = evt_q;
    assign sig       = sig_q;
    assign now       = now_q;
    assign count     = count_q;

endmodule
